// File: rtl/result_packet_tx.sv
// ---------------------------------------------------------------------------
// result_packet_tx
//
// Transmit-side framer for the matrix-multiply link. When a 2x2 result is
// ready, a start pulse captures the job ID and the four result elements.
// The block then hands a byte packet to the UART transmitter, one byte per
// valid/ready handshake:
//
//     0xFF (header), 0x02 (result type), job_id, c11, c12, c21, c22
//
// This framing mirrors the host-to-FPGA command framing, so both directions
// can be parsed by the same state machine on the host side.
//
// Optional feature, selected by the macro RESULT_CHECKSUM_EN:
//   When RESULT_CHECKSUM_EN is defined, an eighth byte follows c22. It holds
//   the XOR of every byte after the header (type, job_id, c11, c12, c21,
//   c22). When the macro is undefined, the packet is seven bytes long and
//   done follows the c22 transfer.
//
// Parameters:
//   HEADER_BYTE - first byte of every packet
//   RESULT_TYPE - type byte that marks a result packet
//   GAP_CYCLES  - idle cycles with tx_valid low after each transfer
//                 (0 = back-to-back bytes)
//
// Ports:
//   clk       in   system clock
//   rst_n     in   synchronous active-low reset
//   start     in   pulse: capture job_id/c11..c22 and begin a packet
//   job_id    in   job ID echoed in the packet
//   c11..c22  in   result matrix elements
//   tx_ready  in   UART transmitter can accept a byte this cycle
//   tx_byte   out  byte presented to the UART transmitter
//   tx_valid  out  tx_byte is valid
//   busy      out  packet in progress (start is ignored)
//   done      out  one-cycle pulse after the final byte is accepted
// ---------------------------------------------------------------------------
module result_packet_tx #(
    parameter logic [7:0]  HEADER_BYTE = 8'hFF,
    parameter logic [7:0]  RESULT_TYPE = 8'h02,
    parameter int unsigned GAP_CYCLES  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] job_id,
    input  logic [7:0] c11,
    input  logic [7:0] c12,
    input  logic [7:0] c21,
    input  logic [7:0] c22,
    input  logic       tx_ready,
    output logic [7:0] tx_byte,
    output logic       tx_valid,
    output logic       busy,
    output logic       done
);

    // The gap counter is at least one bit wide. This keeps the declarations
    // legal when GAP_CYCLES is 0 and the counter never leaves zero.
    localparam int unsigned     GapW    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GapW-1:0] GapLoad = GapW'(GAP_CYCLES);
    localparam logic [GapW-1:0] GapOne  = GapW'(1);

    // Each sending state names the byte that is on tx_byte, or the byte that
    // is waiting out the gap before tx_valid rises.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HEADER = 3'd1,
        S_TYPE   = 3'd2,
        S_JOB    = 3'd3,
        S_DATA   = 3'd4,
`ifdef RESULT_CHECKSUM_EN
        S_CHK    = 3'd5,
`endif
        S_DONE   = 3'd6
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        dataIdx_q, dataIdx_d;
    logic [GapW-1:0]   gapCnt_q, gapCnt_d;
    logic [7:0]        txByte_q, txByte_d;
    logic              txValid_q, txValid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [7:0]        jobId_q, jobId_d;
    logic [7:0]        c11_q, c11_d;
    logic [7:0]        c12_q, c12_d;
    logic [7:0]        c21_q, c21_d;
    logic [7:0]        c22_q, c22_d;
`ifdef RESULT_CHECKSUM_EN
    logic [7:0]        chkAcc_q, chkAcc_d;
`endif

    logic              xfer;
    logic              moveOn;
    logic              finish;
    state_e            nextState;
    logic [7:0]        nextByte;
    logic [1:0]        nextIdx;
    logic [7:0]        nextData;

    // A byte leaves the block on any edge where the handshake completes.
    assign xfer    = txValid_q && tx_ready;
    assign nextIdx = dataIdx_q + 2'd1;

    // Selects the payload byte that follows the current data index.
    always_comb begin
        nextData = c11_q;
        case (nextIdx)
            2'd0:    nextData = c11_q;
            2'd1:    nextData = c12_q;
            2'd2:    nextData = c21_q;
            default: nextData = c22_q;
        endcase
    end

    // Next-state logic. The case statement only decides where a transfer
    // leads: moveOn means "present another byte" and finish means "the
    // packet is complete". The shared code after the case applies the gap
    // timing, so each state does not repeat it.
    always_comb begin
        state_d   = state_q;
        dataIdx_d = dataIdx_q;
        gapCnt_d  = gapCnt_q;
        txByte_d  = txByte_q;
        txValid_d = txValid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        jobId_d   = jobId_q;
        c11_d     = c11_q;
        c12_d     = c12_q;
        c21_d     = c21_q;
        c22_d     = c22_q;
`ifdef RESULT_CHECKSUM_EN
        chkAcc_d  = chkAcc_q;
`endif
        moveOn    = 1'b0;
        finish    = 1'b0;
        nextState = state_q;
        nextByte  = txByte_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    jobId_d   = job_id;
                    c11_d     = c11;
                    c12_d     = c12;
                    c21_d     = c21;
                    c22_d     = c22;
                    dataIdx_d = 2'd0;
                    gapCnt_d  = '0;
                    txByte_d  = HEADER_BYTE;
                    txValid_d = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = S_HEADER;
`ifdef RESULT_CHECKSUM_EN
                    chkAcc_d  = 8'h00;
`endif
                end
            end

            S_HEADER: begin
                if (xfer) begin
                    moveOn    = 1'b1;
                    nextState = S_TYPE;
                    nextByte  = RESULT_TYPE;
                end
            end

            S_TYPE: begin
                if (xfer) begin
                    moveOn    = 1'b1;
                    nextState = S_JOB;
                    nextByte  = jobId_q;
`ifdef RESULT_CHECKSUM_EN
                    chkAcc_d  = chkAcc_q ^ txByte_q;
`endif
                end
            end

            S_JOB: begin
                if (xfer) begin
                    moveOn    = 1'b1;
                    nextState = S_DATA;
                    nextByte  = c11_q;
                    dataIdx_d = 2'd0;
`ifdef RESULT_CHECKSUM_EN
                    chkAcc_d  = chkAcc_q ^ txByte_q;
`endif
                end
            end

            S_DATA: begin
                if (xfer) begin
`ifdef RESULT_CHECKSUM_EN
                    chkAcc_d = chkAcc_q ^ txByte_q;
`endif
                    if (dataIdx_q == 2'd3) begin
`ifdef RESULT_CHECKSUM_EN
                        // Fold in c22 as it leaves, so the checksum byte is
                        // ready without an extra cycle.
                        moveOn    = 1'b1;
                        nextState = S_CHK;
                        nextByte  = chkAcc_q ^ txByte_q;
`else
                        finish    = 1'b1;
`endif
                    end else begin
                        moveOn    = 1'b1;
                        nextState = S_DATA;
                        nextByte  = nextData;
                        dataIdx_d = nextIdx;
                    end
                end
            end

`ifdef RESULT_CHECKSUM_EN
            S_CHK: begin
                if (xfer) begin
                    finish = 1'b1;
                end
            end
`endif

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d   = S_IDLE;
                txValid_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase

        // Gap countdown: tx_valid rises on the edge where the counter
        // leaves 1. The next byte has already been loaded by then.
        if (gapCnt_q != '0) begin
            gapCnt_d = gapCnt_q - GapOne;
            if (gapCnt_q == GapOne) begin
                txValid_d = 1'b1;
            end
        end

        if (moveOn) begin
            state_d   = nextState;
            txByte_d  = nextByte;
            txValid_d = (GAP_CYCLES == 0);
            gapCnt_d  = GapLoad;
        end

        // Completion skips the gap. done and the low busy appear together
        // in S_DONE.
        if (finish) begin
            state_d   = S_DONE;
            txValid_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            dataIdx_d = 2'd0;
            gapCnt_d  = '0;
        end
    end

    // State register. Reset clears the captured data too, so an aborted
    // packet leaves nothing behind.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            dataIdx_q <= 2'd0;
            gapCnt_q  <= '0;
            txByte_q  <= 8'h00;
            txValid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            jobId_q   <= 8'h00;
            c11_q     <= 8'h00;
            c12_q     <= 8'h00;
            c21_q     <= 8'h00;
            c22_q     <= 8'h00;
`ifdef RESULT_CHECKSUM_EN
            chkAcc_q  <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            dataIdx_q <= dataIdx_d;
            gapCnt_q  <= gapCnt_d;
            txByte_q  <= txByte_d;
            txValid_q <= txValid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            jobId_q   <= jobId_d;
            c11_q     <= c11_d;
            c12_q     <= c12_d;
            c21_q     <= c21_d;
            c22_q     <= c22_d;
`ifdef RESULT_CHECKSUM_EN
            chkAcc_q  <= chkAcc_d;
`endif
        end
    end

    assign tx_byte  = txByte_q;
    assign tx_valid = txValid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_result_packet_tx.sv
// ---------------------------------------------------------------------------
// tb_result_packet_tx
//
// Directed testbench for result_packet_tx. It uses two instances: one with
// back-to-back bytes (GAP_CYCLES=0) and one with GAP_CYCLES=3. The expected
// packets are computed here from the job ID and matrix values. When
// RESULT_CHECKSUM_EN is defined, the expected packet includes the XOR
// checksum byte.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_result_packet_tx;

`ifdef RESULT_CHECKSUM_EN
    localparam int PktLen = 8;
`else
    localparam int PktLen = 7;
`endif
    localparam int GapN = 3;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       startG;
    logic [7:0] jobId;
    logic [7:0] c11, c12, c21, c22;
    logic       txReady;
    logic [7:0] txByte, txByteG;
    logic       txValid, txValidG;
    logic       busy, busyG;
    logic       done, doneG;

    int         checks;
    int         errors;

    logic [7:0] expB [0:7];
    logic [7:0] got [0:15];
    int         xferCyc [0:15];
    int         gotN;
    int         doneCount;
    int         doneCycle;
    int         stableErr;
    int         lowCycles;
    bit         timedOut;

    result_packet_tx #(
        .HEADER_BYTE(8'hFF),
        .RESULT_TYPE(8'h02),
        .GAP_CYCLES (0)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .job_id  (jobId),
        .c11     (c11),
        .c12     (c12),
        .c21     (c21),
        .c22     (c22),
        .tx_ready(txReady),
        .tx_byte (txByte),
        .tx_valid(txValid),
        .busy    (busy),
        .done    (done)
    );

    result_packet_tx #(
        .HEADER_BYTE(8'hFF),
        .RESULT_TYPE(8'h02),
        .GAP_CYCLES (GapN)
    ) dutGap (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (startG),
        .job_id  (jobId),
        .c11     (c11),
        .c12     (c12),
        .c21     (c21),
        .c22     (c22),
        .tx_ready(txReady),
        .tx_byte (txByteG),
        .tx_valid(txValidG),
        .busy    (busyG),
        .done    (doneG)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Builds the expected byte sequence from the job ID and matrix values.
    task automatic buildExp(input logic [7:0] j, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
        expB[0] = 8'hFF;
        expB[1] = 8'h02;
        expB[2] = j;
        expB[3] = a;
        expB[4] = b;
        expB[5] = c;
        expB[6] = d;
        expB[7] = 8'h02 ^ j ^ a ^ b ^ c ^ d;
    endtask

    // Drives the packet inputs and pulses start for one cycle. The task
    // returns 1 ns after the edge that sampled start.
    task automatic pulseStart(input bit useGap, input logic [7:0] j, input logic [7:0] a,
                              input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        jobId = j;
        c11   = a;
        c12   = b;
        c21   = c;
        c22   = d;
        if (useGap) startG = 1'b1;
        else        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        startG = 1'b0;
    endtask

    // Drives tx_ready and records every handshake until done appears or
    // the cycle budget runs out. The caller checks the recorded results.
    // When poke is set, the task asserts start again mid-packet with a new
    // job ID and later changes c11.
    task automatic runPacket(input bit useGap, input bit pattern, input bit poke, input int budget);
        int         cyc;
        bit         held;
        logic [7:0] heldByte;
        logic       v;
        logic       dn;
        logic [7:0] b;
        logic [15:0] pat;
        pat       = 16'b1001_0110_0011_1010;
        cyc       = 0;
        held      = 1'b0;
        heldByte  = 8'h00;
        gotN      = 0;
        doneCount = 0;
        doneCycle = -1;
        stableErr = 0;
        lowCycles = 0;
        timedOut  = 1'b0;
        while (1) begin
            if (cyc >= budget) begin
                timedOut = 1'b1;
                break;
            end
            v  = useGap ? txValidG : txValid;
            b  = useGap ? txByteG  : txByte;
            dn = useGap ? doneG    : done;
            if (held && !(v && (b == heldByte))) stableErr++;
            if (dn) begin
                doneCount++;
                doneCycle = cyc;
                break;
            end
            txReady = pattern ? pat[cyc % 16] : 1'b1;
            if (poke && cyc == 1) begin
                start = 1'b1;
                jobId = 8'h09;
            end
            if (poke && cyc == 2) start = 1'b0;
            if (poke && cyc == 3) c11 = 8'hAA;
            if (v && txReady) begin
                if (gotN < 16) begin
                    got[gotN]     = b;
                    xferCyc[gotN] = cyc;
                end
                gotN++;
                held = 1'b0;
            end else if (v) begin
                held     = 1'b1;
                heldByte = b;
            end else begin
                held = 1'b0;
                lowCycles++;
            end
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    // Checks the reset values of both instances.
    task automatic test_reset();
        rst_n   = 1'b0;
        start   = 1'b0;
        startG  = 1'b0;
        txReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (txValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_valid: got %b expected 0", txValid); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++;
        if (txByte !== 8'h00) begin errors++; $display("[TB] FAIL reset_tx_byte: got %h expected 00", txByte); end
        checks++;
        if (txValidG !== 1'b0 || busyG !== 1'b0 || doneG !== 1'b0 || txByteG !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_gap_inst: got valid=%b busy=%b done=%b byte=%h expected 0/0/0/00",
                     txValidG, busyG, doneG, txByteG);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (txValid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got valid=%b busy=%b expected 0/0", txValid, busy);
        end
    endtask

    // Checks a basic packet sent with tx_ready held high.
    task automatic test_basic();
        buildExp(8'h05, 8'h01, 8'h02, 8'h03, 8'h04);
        txReady = 1'b1;
        pulseStart(1'b0, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04);
        checks++;
        if (txValid !== 1'b1 || txByte !== 8'hFF || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_first_byte: got valid=%b byte=%h busy=%b expected 1/FF/1", txValid, txByte, busy);
        end
        runPacket(1'b0, 1'b0, 1'b0, 50);
        checks++;
        if (timedOut) begin errors++; $display("[TB] FAIL basic_timeout: got no done expected done within 50 cycles"); end
        checks++;
        if (gotN !== PktLen) begin errors++; $display("[TB] FAIL basic_len: got %0d expected %0d", gotN, PktLen); end
        for (int i = 0; i < PktLen && i < gotN; i++) begin
            checks++;
            if (got[i] !== expB[i]) begin errors++; $display("[TB] FAIL basic_byte%0d: got %h expected %h", i, got[i], expB[i]); end
            checks++;
            if (xferCyc[i] !== i) begin errors++; $display("[TB] FAIL basic_cycle%0d: got %0d expected %0d", i, xferCyc[i], i); end
        end
        checks++;
        if (doneCycle - xferCyc[0] !== PktLen) begin
            errors++;
            $display("[TB] FAIL basic_latency: got %0d expected %0d", doneCycle - xferCyc[0], PktLen);
        end
        checks++;
        if (busy !== 1'b0 || txValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_done_cycle: got busy=%b valid=%b expected 0/0", busy, txValid);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_done_once: got done=%b busy=%b expected 0/0", done, busy);
        end
    endtask

    // Checks that no byte is lost, duplicated or changed while tx_ready
    // toggles in an irregular pattern.
    task automatic test_backpressure();
        buildExp(8'h3C, 8'hA5, 8'h5A, 8'h0F, 8'hF0);
        pulseStart(1'b0, 8'h3C, 8'hA5, 8'h5A, 8'h0F, 8'hF0);
        runPacket(1'b0, 1'b1, 1'b0, 200);
        checks++;
        if (timedOut) begin errors++; $display("[TB] FAIL bp_timeout: got no done expected done within 200 cycles"); end
        checks++;
        if (gotN !== PktLen) begin errors++; $display("[TB] FAIL bp_len: got %0d expected %0d", gotN, PktLen); end
        for (int i = 0; i < PktLen && i < gotN; i++) begin
            checks++;
            if (got[i] !== expB[i]) begin errors++; $display("[TB] FAIL bp_byte%0d: got %h expected %h", i, got[i], expB[i]); end
        end
        checks++;
        if (stableErr !== 0) begin errors++; $display("[TB] FAIL bp_stable: got %0d unstable cycles expected 0", stableErr); end
        checks++;
        if (doneCount !== 1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_done: got done=%0d busy=%b expected 1/0", doneCount, busy);
        end
        @(posedge clk); #1;
    endtask

    // Checks that start pulses are ignored while busy, including in the
    // done cycle, and that inputs changed mid-packet do not affect it.
    task automatic test_start_ignored();
        buildExp(8'h05, 8'h01, 8'h02, 8'h03, 8'h04);
        txReady = 1'b1;
        pulseStart(1'b0, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04);
        runPacket(1'b0, 1'b0, 1'b1, 50);
        checks++;
        if (timedOut) begin errors++; $display("[TB] FAIL ign_timeout: got no done expected done within 50 cycles"); end
        checks++;
        if (gotN !== PktLen) begin errors++; $display("[TB] FAIL ign_len: got %0d expected %0d", gotN, PktLen); end
        for (int i = 0; i < PktLen && i < gotN; i++) begin
            checks++;
            if (got[i] !== expB[i]) begin errors++; $display("[TB] FAIL ign_byte%0d: got %h expected %h", i, got[i], expB[i]); end
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (txValid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL ign_no_second_pkt%0d: got valid=%b busy=%b expected 0/0", i, txValid, busy);
            end
            @(posedge clk); #1;
        end
    endtask

    // Checks the gap instance: exactly GapN low cycles between transfers.
    task automatic test_gap();
        buildExp(8'h21, 8'h11, 8'h22, 8'h33, 8'h44);
        txReady = 1'b1;
        pulseStart(1'b1, 8'h21, 8'h11, 8'h22, 8'h33, 8'h44);
        checks++;
        if (txValidG !== 1'b1 || txByteG !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL gap_first_byte: got valid=%b byte=%h expected 1/FF", txValidG, txByteG);
        end
        runPacket(1'b1, 1'b0, 1'b0, 100);
        checks++;
        if (timedOut) begin errors++; $display("[TB] FAIL gap_timeout: got no done expected done within 100 cycles"); end
        checks++;
        if (gotN !== PktLen) begin errors++; $display("[TB] FAIL gap_len: got %0d expected %0d", gotN, PktLen); end
        for (int i = 0; i < PktLen && i < gotN; i++) begin
            checks++;
            if (got[i] !== expB[i]) begin errors++; $display("[TB] FAIL gap_byte%0d: got %h expected %h", i, got[i], expB[i]); end
            if (i > 0) begin
                checks++;
                if (xferCyc[i] - xferCyc[i-1] !== GapN + 1) begin
                    errors++;
                    $display("[TB] FAIL gap_spacing%0d: got %0d expected %0d", i, xferCyc[i] - xferCyc[i-1], GapN + 1);
                end
            end
        end
        checks++;
        if (lowCycles !== (PktLen - 1) * GapN) begin
            errors++;
            $display("[TB] FAIL gap_low_cycles: got %0d expected %0d", lowCycles, (PktLen - 1) * GapN);
        end
        checks++;
        if (doneCycle - xferCyc[0] !== PktLen + (PktLen - 1) * GapN) begin
            errors++;
            $display("[TB] FAIL gap_total: got %0d expected %0d", doneCycle - xferCyc[0], PktLen + (PktLen - 1) * GapN);
        end
        checks++;
        if (busyG !== 1'b0) begin errors++; $display("[TB] FAIL gap_busy_at_done: got %b expected 0", busyG); end
        @(posedge clk); #1;
    endtask

    // Checks that a reset mid-packet aborts the packet, that reset wins over
    // a simultaneous start, and that a fresh packet follows normally.
    task automatic test_reset_midpacket();
        buildExp(8'h05, 8'h01, 8'h02, 8'h03, 8'h04);
        txReady = 1'b1;
        pulseStart(1'b0, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (txValid !== 1'b1 || txByte !== expB[i]) begin
                errors++;
                $display("[TB] FAIL rst_pre_byte%0d: got valid=%b byte=%h expected 1/%h", i, txValid, txByte, expB[i]);
            end
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (txValid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || txByte !== 8'h00) begin
            errors++;
            $display("[TB] FAIL rst_abort: got valid=%b busy=%b done=%b byte=%h expected 0/0/0/00",
                     txValid, busy, done, txByte);
        end
        rst_n = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (txValid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_wins_over_start: got valid=%b busy=%b done=%b expected 0/0/0", txValid, busy, done);
        end
        buildExp(8'h77, 8'h10, 8'h20, 8'h30, 8'h40);
        pulseStart(1'b0, 8'h77, 8'h10, 8'h20, 8'h30, 8'h40);
        runPacket(1'b0, 1'b0, 1'b0, 50);
        checks++;
        if (timedOut || gotN !== PktLen) begin
            errors++;
            $display("[TB] FAIL rst_fresh_len: got %0d bytes timeout=%b expected %0d bytes", gotN, timedOut, PktLen);
        end
        for (int i = 0; i < PktLen && i < gotN; i++) begin
            checks++;
            if (got[i] !== expB[i]) begin errors++; $display("[TB] FAIL rst_fresh_byte%0d: got %h expected %h", i, got[i], expB[i]); end
        end
        checks++;
        if (doneCount !== 1) begin errors++; $display("[TB] FAIL rst_fresh_done: got %0d expected 1", doneCount); end
        @(posedge clk); #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        startG  = 1'b0;
        txReady = 1'b0;
        jobId   = 8'h00;
        c11     = 8'h00;
        c12     = 8'h00;
        c21     = 8'h00;
        c22     = 8'h00;
        test_reset();
        test_basic();
        test_backpressure();
        test_start_ignored();
        test_gap();
        test_reset_midpacket();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
